// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory subsystem.
//   - Arbiter FSM state encoding (ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE)
//   - Requester port indices (PORT_CPU, PORT_LDR)
//   - Default address/data widths for the 256-byte program/data memory
package cpu_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational two-way round-robin pick.
// Ports:
//   req       in  2  request vector, bit PORT_CPU / PORT_LDR
//   lastGrant in  1  port that won the previous arbitration
//   lock      in  1  port-1 bus lock (tie to 0 when unused)
//   gntValid  out 1  a port is granted this cycle
//   gntPort   out 1  index of the granted port
// Kept free of any sequencing so it can be shared by other port muxes.
module mem_arb_rr
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  input  logic       lock,
  output logic       gntValid,
  output logic       gntPort
);

  always_comb begin
    gntValid = 1'b0;
    gntPort  = PORT_CPU;
    if (lock && (lastGrant == PORT_LDR)) begin
      // A locked loader owns the bus outright: port 0 waits even in the idle
      // gap between two loader transfers, so bursts are never interleaved.
      gntValid = req[PORT_LDR];
      gntPort  = PORT_LDR;
    end else if (req[PORT_CPU] && req[PORT_LDR]) begin
      gntValid = 1'b1;
      gntPort  = ~lastGrant;
    end else if (req[PORT_CPU]) begin
      gntValid = 1'b1;
      gntPort  = PORT_CPU;
    end else if (req[PORT_LDR]) begin
      gntValid = 1'b1;
      gntPort  = PORT_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port program/data memory.
// Port 0 is the CPU fetch/data path, port 1 the loader/debug path.
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   rN_req/we/addr/wdata         requester N transfer (held until rN_ack)
//   rN_ack, rN_rdata             one-cycle completion pulse, registered read data
//   r1_lock                      loader bus lock (only with MEM_ARB_LOCK_EN)
//   mem_addr/we/wdata/rdata      memory array interface
//   busy                         high whenever the FSM is not IDLE
// Build option: define MEM_ARB_LOCK_EN to add r1_lock; otherwise arbitration
// is pure round-robin.
// Access sequence: IDLE -> ACCESS -> (reads: WAIT x RD_LAT) -> DONE -> IDLE.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic          r1_lock,
`endif
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int            CW       = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
  localparam logic [CW-1:0] LAST_CNT = CW'(RD_LAT - 1);

  logic [1:0]    state;
  logic [1:0]    nextState;
  logic          grantPort;
  logic          lastGrant;
  logic          capWe;
  logic [CW-1:0] waitCnt;
  logic          gntValid;
  logic          gntPort;
  logic          lockReq;

`ifdef MEM_ARB_LOCK_EN
  assign lockReq = r1_lock;
`else
  assign lockReq = 1'b0;
`endif

  mem_arb_rr uArb (
    .req      ({r1_req, r0_req}),
    .lastGrant(lastGrant),
    .lock     (lockReq),
    .gntValid (gntValid),
    .gntPort  (gntPort)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state logic
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (gntValid) nextState = ST_ACCESS;
      ST_ACCESS: nextState = capWe ? ST_DONE : ST_WAIT;
      ST_WAIT:   if (waitCnt == LAST_CNT) nextState = ST_DONE;
      ST_DONE:   nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  // FSM outputs: strobes and acks decode straight from state so each is
  // exactly one cycle wide.
  always_comb begin
    busy   = (state != ST_IDLE);
    mem_we = (state == ST_ACCESS) && capWe;
    r0_ack = (state == ST_DONE) && (grantPort == PORT_CPU);
    r1_ack = (state == ST_DONE) && (grantPort == PORT_LDR);
  end

  // Transfer capture and read-data return. The request is captured straight
  // into mem_addr/mem_wdata at grant, so the memory sees it during ACCESS
  // and later changes on the requester side cannot leak through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grantPort <= PORT_CPU;
      lastGrant <= PORT_LDR;
      capWe     <= 1'b0;
      waitCnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gntValid) begin
            grantPort <= gntPort;
            lastGrant <= gntPort;
            if (gntPort == PORT_LDR) begin
              capWe     <= r1_we;
              mem_addr  <= r1_addr;
              mem_wdata <= r1_wdata;
            end else begin
              capWe     <= r0_we;
              mem_addr  <= r0_addr;
              mem_wdata <= r0_wdata;
            end
          end
        end
        ST_ACCESS: begin
          waitCnt <= '0;
        end
        ST_WAIT: begin
          waitCnt <= waitCnt + 1'b1;
          // mem_rdata becomes valid in the last WAIT cycle (RD_LAT after ACCESS).
          if (waitCnt == LAST_CNT) begin
            if (grantPort == PORT_LDR) begin
              r1_rdata <= mem_rdata;
            end else begin
              r0_rdata <= mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic       clk;
  logic       reset_n;
  logic       r0_req, r0_we, r0_ack;
  logic [7:0] r0_addr, r0_wdata, r0_rdata;
  logic       r1_req, r1_we, r1_ack;
  logic [7:0] r1_addr, r1_wdata, r1_rdata;
`ifdef MEM_ARB_LOCK_EN
  logic       r1_lock;
`endif
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic       busy;

  int checks;
  int failures;

  // Memory model: synchronous read, one cycle latency (RD_LAT = 1).
  logic [7:0] mem [256];
  logic       ldEn;
  logic [7:0] ldAddr, ldData;

  always @(posedge clk) begin
    if (ldEn) mem[ldAddr] <= ldData;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  mem_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .r0_req   (r0_req),
    .r0_we    (r0_we),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_ack   (r0_ack),
    .r0_rdata (r0_rdata),
    .r1_req   (r1_req),
    .r1_we    (r1_we),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_ack   (r1_ack),
    .r1_rdata (r1_rdata),
`ifdef MEM_ARB_LOCK_EN
    .r1_lock  (r1_lock),
`endif
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    ldEn = 1'b1; ldAddr = a; ldData = d;
    tick();
    ldEn = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({r0_ack, r1_ack, mem_we} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {r0_ack, r1_ack, mem_we}); end
    checks++; if ({mem_addr, mem_wdata} !== 16'h0000) begin failures++; $display("FAIL reset_mem got=%h exp=0000", {mem_addr, mem_wdata}); end
    checks++; if ({r0_rdata, r1_rdata} !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", {r0_rdata, r1_rdata}); end
    reset_n = 1'b1;
    tick();
  endtask

  // r0 read 0x05 (0xA7): ack in cycle 3, busy low in cycle 4.
  task automatic test_read();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h05;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_c0 got=%b exp=0", busy); end
    tick();
    checks++; if (mem_addr !== 8'h05) begin failures++; $display("FAIL rd_addr_c1 got=%h exp=05", mem_addr); end
    checks++; if ({busy, mem_we} !== 2'b10) begin failures++; $display("FAIL rd_busy_we_c1 got=%b exp=10", {busy, mem_we}); end
    tick();
    checks++; if (r0_ack !== 1'b0) begin failures++; $display("FAIL rd_ack_c2 got=%b exp=0", r0_ack); end
    tick();
    checks++; if ({r0_ack, r1_ack} !== 2'b10) begin failures++; $display("FAIL rd_ack_c3 got=%b exp=10", {r0_ack, r1_ack}); end
    checks++; if (r0_rdata !== 8'hA7) begin failures++; $display("FAIL rd_data got=%h exp=a7", r0_rdata); end
    tick();
    r0_req = 1'b0;
    checks++; if ({busy, r0_ack} !== 2'b00) begin failures++; $display("FAIL rd_c4 got=%b exp=00", {busy, r0_ack}); end
  endtask

  // r1 write 0x10 <= 0x3C, then r0 reads it back.
  task automatic test_write();
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h10; r1_wdata = 8'h3C;
    tick();
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h10, 8'h3C}) begin failures++; $display("FAIL wr_c1 got=%b/%h/%h exp=1/10/3c", mem_we, mem_addr, mem_wdata); end
    checks++; if (r1_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_c1 got=%b exp=0", r1_ack); end
    tick();
    checks++; if ({mem_we, r1_ack, r0_ack} !== 3'b010) begin failures++; $display("FAIL wr_c2 got=%b exp=010", {mem_we, r1_ack, r0_ack}); end
    tick();
    r1_req = 1'b0;
    checks++; if ({mem_we, r1_ack, busy} !== 3'b000) begin failures++; $display("FAIL wr_c3 got=%b exp=000", {mem_we, r1_ack, busy}); end
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
    tick(); tick(); tick();
    checks++; if ({r0_ack, r0_rdata} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL wr_readback got=%b/%h exp=1/3c", r0_ack, r0_rdata); end
    tick();
    r0_req = 1'b0;
  endtask

  // Both ports requesting from reset: grants alternate 0,1,0,1.
  task automatic test_round_robin();
    int     nAcks;
    int     cyc;
    logic   seq [4];
    logic   prevAck;
    reset_n = 1'b0;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h30; r1_wdata = 8'h55;
    tick();
    reset_n = 1'b1;
    nAcks = 0; cyc = 0; prevAck = 1'b0;
    while (nAcks < 4 && cyc < 40) begin
      tick();
      cyc++;
      checks++; if (r0_ack && r1_ack) begin failures++; $display("FAIL rr_dual_ack got=11 exp=not both"); end
      if (r0_ack || r1_ack) begin
        checks++; if (prevAck) begin failures++; $display("FAIL rr_ack_width got=2 cycles exp=1"); end
        seq[nAcks] = r1_ack;
        if (r0_ack) begin
          checks++; if (r0_rdata !== 8'h3C) begin failures++; $display("FAIL rr_r0_data got=%h exp=3c", r0_rdata); end
        end
        nAcks++;
        if (nAcks == 4) begin r0_req = 1'b0; r1_req = 1'b0; end
      end
      prevAck = r0_ack | r1_ack;
    end
    checks++; if (nAcks != 4) begin failures++; $display("FAIL rr_ack_count got=%0d exp=4", nAcks); end
    else begin
      checks++; if ({seq[0], seq[1], seq[2], seq[3]} !== 4'b0101) begin failures++; $display("FAIL rr_order got=%b exp=0101", {seq[0], seq[1], seq[2], seq[3]}); end
    end
    tick();
    checks++; if (mem[8'h30] !== 8'h55) begin failures++; $display("FAIL rr_r1_write got=%h exp=55", mem[8'h30]); end
  endtask

  // Reset during WAIT: cleared immediately, no ack; then r1 served alone.
  task automatic test_reset_midway();
    bit sawAck;
    tick();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h05;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_busy_wait got=%b exp=1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, r0_ack, mem_addr, r0_rdata} !== 18'h0) begin failures++; $display("FAIL rm_cleared got=%b/%b/%h/%h exp=0/0/00/00", busy, r0_ack, mem_addr, r0_rdata); end
    r0_req = 1'b0;
    sawAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (r0_ack || r1_ack) sawAck = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (r0_ack || r1_ack) sawAck = 1'b1;
    end
    checks++; if (sawAck) begin failures++; $display("FAIL rm_no_ack got=ack exp=none"); end
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h10;
    tick();
    checks++; if (mem_addr !== 8'h10) begin failures++; $display("FAIL rm_r1_addr got=%h exp=10", mem_addr); end
    tick(); tick();
    checks++; if ({r1_ack, r0_ack, r1_rdata} !== {2'b10, 8'h3C}) begin failures++; $display("FAIL rm_r1_read got=%b/%b/%h exp=1/0/3c", r1_ack, r0_ack, r1_rdata); end
    checks++; if (r0_rdata !== 8'h00) begin failures++; $display("FAIL rm_r0_hold got=%h exp=00", r0_rdata); end
    tick();
    r1_req = 1'b0;
  endtask

  // Address or request changed mid-transfer has no effect.
  task automatic test_addr_change();
    preload(8'h20, 8'h11);
    preload(8'h21, 8'h22);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h20;
    tick();
    checks++; if (mem_addr !== 8'h20) begin failures++; $display("FAIL ac_addr_c1 got=%h exp=20", mem_addr); end
    r0_addr = 8'h21;
    tick();
    checks++; if (mem_addr !== 8'h20) begin failures++; $display("FAIL ac_addr_c2 got=%h exp=20", mem_addr); end
    tick();
    checks++; if ({r0_ack, r0_rdata} !== {1'b1, 8'h11}) begin failures++; $display("FAIL ac_read got=%b/%h exp=1/11", r0_ack, r0_rdata); end
    tick();
    r0_req = 1'b0;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h40; r1_wdata = 8'h99;
    tick();
    r1_req = 1'b0; r1_addr = 8'h41; r1_wdata = 8'h00;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h40, 8'h99}) begin failures++; $display("FAIL ac_wr_c1 got=%b/%h/%h exp=1/40/99", mem_we, mem_addr, mem_wdata); end
    tick();
    checks++; if (r1_ack !== 1'b1) begin failures++; $display("FAIL ac_drop_ack got=%b exp=1", r1_ack); end
    tick();
    checks++; if (mem[8'h40] !== 8'h99) begin failures++; $display("FAIL ac_mem40 got=%h exp=99", mem[8'h40]); end
  endtask

  // Held write request: second grant 3 cycles after the first, acks at 2 and 5.
  task automatic test_back_to_back();
    logic [3:0] ackPat;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h50; r0_wdata = 8'h77;
    tick(); tick();
    ackPat[3] = r0_ack;
    tick(); ackPat[2] = r0_ack;
    tick();
    ackPat[1] = r0_ack;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL b2b_we_c4 got=%b exp=1", mem_we); end
    tick(); ackPat[0] = r0_ack;
    r0_req = 1'b0;
    checks++; if (ackPat !== 4'b1001) begin failures++; $display("FAIL b2b_ack_pattern got=%b exp=1001", ackPat); end
    tick();
    checks++; if ({busy, r0_ack} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {busy, r0_ack}); end
  endtask

`ifdef MEM_ARB_LOCK_EN
  // Locked loader wins three times, then port 0 once lock drops.
  task automatic test_lock();
    int   nAcks;
    int   cyc;
    logic seq [4];
    reset_n = 1'b0;
    r1_lock = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h05;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h10;
    tick();
    reset_n = 1'b1;
    nAcks = 0; cyc = 0;
    while (nAcks < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (r0_ack || r1_ack) begin
        seq[nAcks] = r1_ack;
        nAcks++;
        if (nAcks == 3) r1_lock = 1'b0;
        if (nAcks == 4) begin r0_req = 1'b0; r1_req = 1'b0; end
      end
    end
    checks++; if (nAcks != 4) begin failures++; $display("FAIL lock_ack_count got=%0d exp=4", nAcks); end
    else begin
      checks++; if ({seq[0], seq[1], seq[2], seq[3]} !== 4'b1110) begin failures++; $display("FAIL lock_order got=%b exp=1110", {seq[0], seq[1], seq[2], seq[3]}); end
    end
    tick();
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    r1_lock = 1'b0;
`endif
    ldEn = 1'b0; ldAddr = '0; ldData = '0;
    tick();
    preload(8'h05, 8'hA7);
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_reset_midway();
    test_addr_change();
    test_back_to_back();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
